// File: rtl/line_demultiplexer.sv
// line_demultiplexer: steers single or burst write beats into eight line registers.
// Optional LINE_DEMUX_INVALIDATE_EN adds inv_all to flush line_valid.
module line_demultiplexer #(
  parameter int LINE_W    = 37,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef LINE_DEMUX_INVALIDATE_EN
  input  logic              inv_all,
`endif
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_sel,
  input  logic              wr_burst,
  input  logic [LINE_W-1:0] wr_data,
  output logic [LINE_W-1:0] data0x,
  output logic [LINE_W-1:0] data1x,
  output logic [LINE_W-1:0] data2x,
  output logic [LINE_W-1:0] data3x,
  output logic [LINE_W-1:0] data4x,
  output logic [LINE_W-1:0] data5x,
  output logic [LINE_W-1:0] data6x,
  output logic [LINE_W-1:0] data7x,
  output logic [7:0]        line_valid,
  output logic              fill_done
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  localparam logic [3:0] REM_INIT = 4'(BURST_LEN - 1);
  localparam bit         MULTI    = (BURST_LEN > 1);

  state_t            state;
  logic [2:0]        ptr;
  logic [3:0]        remaining;
  logic [LINE_W-1:0] lines [8];
  logic              inv;
  logic              accept;

`ifdef LINE_DEMUX_INVALIDATE_EN
  assign inv = inv_all;
`else
  assign inv = 1'b0;
`endif

  // ready tracks reset directly so no beat is lost on the release cycle
  assign wr_ready = rst_n & ~inv;
  assign accept   = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      line_valid <= '0;
      fill_done  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        lines[i] <= '0;
      end
    end else begin
      fill_done <= 1'b0;
      if (inv) begin
        // flush drops the burst but keeps the payload registers
        state      <= IDLE;
        ptr        <= '0;
        remaining  <= '0;
        line_valid <= '0;
      end else if (accept) begin
        unique case (state)
          IDLE: begin
            lines[wr_sel]      <= wr_data;
            line_valid[wr_sel] <= 1'b1;
            if (wr_burst && MULTI) begin
              ptr       <= wr_sel + 3'd1;
              remaining <= REM_INIT;
              state     <= FILL;
            end else begin
              fill_done <= 1'b1;
            end
          end
          FILL: begin
            lines[ptr]      <= wr_data;
            line_valid[ptr] <= 1'b1;
            ptr             <= ptr + 3'd1;
            remaining       <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              state     <= IDLE;
              fill_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign data0x = lines[0];
  assign data1x = lines[1];
  assign data2x = lines[2];
  assign data3x = lines[3];
  assign data4x = lines[4];
  assign data5x = lines[5];
  assign data6x = lines[6];
  assign data7x = lines[7];

endmodule

// File: tb/tb_line_demultiplexer.sv
// tb_line_demultiplexer: vector table plus scoreboard, with hand sequences
// for gapped bursts, reset mid-burst and (optionally) inv_all flush.
module tb_line_demultiplexer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_sel = '0;
  logic        wr_burst = 1'b0;
  logic [36:0] wr_data = '0;
  logic [36:0] dout [8];
  logic [7:0]  line_valid;
  logic        fill_done;
`ifdef LINE_DEMUX_INVALIDATE_EN
  logic        inv_all = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_demultiplexer #(.LINE_W(37), .BURST_LEN(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef LINE_DEMUX_INVALIDATE_EN
    .inv_all(inv_all),
`endif
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_sel(wr_sel),
    .wr_burst(wr_burst),
    .wr_data(wr_data),
    .data0x(dout[0]),
    .data1x(dout[1]),
    .data2x(dout[2]),
    .data3x(dout[3]),
    .data4x(dout[4]),
    .data5x(dout[5]),
    .data6x(dout[6]),
    .data7x(dout[7]),
    .line_valid(line_valid),
    .fill_done(fill_done)
  );

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic        b;
    logic [36:0] d;
    logic [7:0]  lv;
    logic        fd;
    int          idx;
    logic [36:0] val;
  } vec_t;

  vec_t vecs [19];
  vec_t sb [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s,
                       input logic b, input logic [36:0] d);
    wr_valid = v;
    wr_sel   = s;
    wr_burst = b;
    wr_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int i = 0; i < 8; i++) chk({nm, "_data"}, 64'(dout[i]), 64'd0);
    chk({nm, "_lv"}, 64'(line_valid), 64'd0);
    chk({nm, "_fd"}, 64'(fill_done), 64'd0);
    chk({nm, "_ready"}, 64'(wr_ready), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] exp_d [8];
    vec_t e;

    // v sel b data | lv fd idx val
    vecs[0]  = '{1, 5, 0, 37'h1_2345_6789, 8'h20, 1, 5, 37'h1_2345_6789};
    vecs[1]  = '{0, 0, 0, 37'h0,  8'h20, 0, 5, 37'h1_2345_6789};
    vecs[2]  = '{1, 0, 0, 37'hA,  8'h21, 1, 0, 37'hA};
    vecs[3]  = '{1, 0, 0, 37'hB,  8'h21, 1, 0, 37'hB};
    vecs[4]  = '{0, 0, 0, 37'h0,  8'h21, 0, 0, 37'hB};
    vecs[5]  = '{1, 6, 1, 37'h1,  8'h61, 0, 6, 37'h1};
    vecs[6]  = '{1, 3, 1, 37'h2,  8'hE1, 0, 7, 37'h2};
    vecs[7]  = '{1, 1, 0, 37'h3,  8'hE1, 0, 0, 37'h3};
    vecs[8]  = '{1, 0, 1, 37'h4,  8'hE3, 0, 1, 37'h4};
    vecs[9]  = '{1, 7, 0, 37'h5,  8'hE7, 0, 2, 37'h5};
    vecs[10] = '{1, 2, 1, 37'h6,  8'hEF, 0, 3, 37'h6};
    vecs[11] = '{1, 4, 0, 37'h7,  8'hFF, 0, 4, 37'h7};
    vecs[12] = '{1, 0, 0, 37'h8,  8'hFF, 1, 5, 37'h8};
    vecs[13] = '{0, 0, 0, 37'h0,  8'hFF, 0, 5, 37'h8};
    vecs[14] = '{1, 3, 0, 37'h99, 8'hFF, 1, 3, 37'h99};
    vecs[15] = '{1, 3, 0, 37'h1F_FFFF_FFFF, 8'hFF, 1, 3, 37'h1F_FFFF_FFFF};
    vecs[16] = '{0, 5, 1, 37'h55, 8'hFF, 0, 5, 37'h8};
    vecs[17] = '{1, 7, 1, 37'h42, 8'hFF, 0, 7, 37'h42};
    vecs[18] = '{1, 0, 0, 37'h43, 8'hFF, 0, 0, 37'h43};

    // reset state
    drive(1'b1, 3'd2, 1'b0, 37'h77);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    chk_all_zero("reset_hold");
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, '0);
    #1;
    chk("ready_after_rst", 64'(wr_ready), 64'd1);

    // table: single, back-to-back, burst with wrap, write on fill_done
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].b, vecs[i].d);
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_data", i), 64'(dout[e.idx]), 64'(e.val));
      chk($sformatf("v%0d_lv", i), 64'(line_valid), 64'(e.lv));
      chk($sformatf("v%0d_fd", i), 64'(fill_done), 64'(e.fd));
    end
    // finish the burst left open by vecs[17..18] (6 beats to go)
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'd0, 1'b0, 37'(k));
      @(negedge clk);
      chk("open_burst_fd", 64'(fill_done), (k == 5) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 3'd0, 1'b0, '0);

    // burst with 3-cycle gaps between beats
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'd6, 1'b1, 37'(k + 1));
      exp_d[(6 + k) % 8] = 37'(k + 1);
      @(negedge clk);
      chk("gap_fd", 64'(fill_done), (k == 7) ? 64'd1 : 64'd0);
      drive(1'b0, 3'd0, 1'b0, '0);
      if (k < 7) begin
        for (int g = 0; g < 3; g++) begin
          chk("gap_ready", 64'(wr_ready), 64'd1);
          @(negedge clk);
          chk("gap_no_fd", 64'(fill_done), 64'd0);
        end
      end
    end
    @(negedge clk);
    chk("gap_fd_once", 64'(fill_done), 64'd0);
    chk("gap_lv", 64'(line_valid), 64'hFF);
    for (int i = 0; i < 8; i++) chk("gap_data", 64'(dout[i]), 64'(exp_d[i]));

    // reset after beat 3 of a burst
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd2, 1'b1, 37'(16 + k));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    chk_all_zero("mid_rst_hold");
    drive(1'b0, 3'd0, 1'b0, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_fd", 64'(fill_done), 64'd0);
    drive(1'b1, 3'd5, 1'b0, 37'h1_2345_6789);
    @(negedge clk);
    drive(1'b0, 3'd0, 1'b0, '0);
    chk("post_rst_data5", 64'(dout[5]), 64'h1_2345_6789);
    chk("post_rst_data1", 64'(dout[1]), 64'd0);
    chk("post_rst_lv", 64'(line_valid), 64'h20);
    chk("post_rst_fd", 64'(fill_done), 64'd1);
    @(negedge clk);
    chk("post_rst_fd_end", 64'(fill_done), 64'd0);

`ifdef LINE_DEMUX_INVALIDATE_EN
    // flush during beat 4 of a burst
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 1'b1, 37'(k + 1));
      @(negedge clk);
    end
    drive(1'b1, 3'd0, 1'b1, 37'h4);
    inv_all = 1'b1;
    #1;
    chk("inv_ready", 64'(wr_ready), 64'd0);
    @(negedge clk);
    inv_all = 1'b0;
    drive(1'b0, 3'd0, 1'b0, '0);
    chk("inv_lv", 64'(line_valid), 64'd0);
    chk("inv_fd", 64'(fill_done), 64'd0);
    chk("inv_d0", 64'(dout[0]), 64'd1);
    chk("inv_d2", 64'(dout[2]), 64'd3);
    chk("inv_d3", 64'(dout[3]), 64'd0);
    drive(1'b1, 3'd4, 1'b0, 37'h66);
    @(negedge clk);
    drive(1'b0, 3'd0, 1'b0, '0);
    chk("inv_idle_d4", 64'(dout[4]), 64'h66);
    chk("inv_idle_lv", 64'(line_valid), 64'h10);
    chk("inv_idle_fd", 64'(fill_done), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_demultiplexer.md
LINE_DEMULTIPLEXER -- requirements
Module: line_demultiplexer

Interface
REQ-001 The block SHALL have parameter LINE_W, default 37, giving the line width in bits.
REQ-002 The block SHALL have parameter BURST_LEN, default 8, giving beats per burst fill (legal 1..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: a write beat is offered.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the block accepts the offered beat.
REQ-007 The block SHALL have port wr_sel, input, 3 bits: target line index of a first beat.
REQ-008 The block SHALL have port wr_burst, input, 1 bit: the first beat starts a BURST_LEN-beat fill.
REQ-009 The block SHALL have port wr_data, input, LINE_W bits: the line payload.
REQ-010 The block SHALL have ports data0x..data7x, output, LINE_W bits each: the registered line entries 0..7.
REQ-011 The block SHALL have port line_valid, output, 8 bits: bit i set means entry i holds written data.
REQ-012 The block SHALL have port fill_done, output, 1 bit: a one-cycle pulse marking completion of a single write or burst.

Function
REQ-013 A beat SHALL be accepted in any cycle where wr_valid and wr_ready are both 1.
REQ-014 The FSM SHALL have two states: IDLE and FILL.
REQ-015 wr_ready SHALL be 1 in both IDLE and FILL whenever rst_n is 1 (subject to REQ-026).
REQ-016 In IDLE, an accepted beat SHALL write wr_data into entry wr_sel and set line_valid[wr_sel].
REQ-017 In IDLE with wr_burst=0, or with BURST_LEN=1, the FSM SHALL remain in IDLE, and fill_done SHALL pulse in the next cycle.
REQ-018 In IDLE with wr_burst=1 and BURST_LEN>1, the block SHALL load ptr=(wr_sel+1) mod 8 and remaining=BURST_LEN-1, then go to FILL.
REQ-019 In FILL, each accepted beat SHALL write entry ptr, set line_valid[ptr], increment ptr mod 8 (7 wraps to 0) and decrement remaining; wr_sel and wr_burst SHALL be ignored.
REQ-020 When the beat with remaining=1 is accepted, the FSM SHALL return to IDLE, and fill_done SHALL pulse in the next cycle.
REQ-021 In FILL with wr_valid=0, all state SHALL hold; idle cycles inside a burst are unbounded.
REQ-022 A written entry SHALL appear on its dataNx output exactly one cycle after acceptance; no other entry changes.
REQ-023 Rewriting an already valid entry SHALL overwrite its data; line_valid stays 1.
REQ-024 An accepted beat in the cycle fill_done is high SHALL be processed normally (back-to-back writes allowed, no bubble).

Reset
REQ-025 While rst_n=0: all dataNx SHALL be 0, line_valid=0, fill_done=0, wr_ready=0, FSM=IDLE, ptr=0 and remaining=0; reset mid-burst SHALL abort the burst with no fill_done.

Configuration
REQ-026 With LINE_DEMUX_INVALIDATE_EN defined, an input port inv_all (1 bit) SHALL exist; while inv_all=1, line_valid SHALL clear to 0 next cycle, wr_ready=0, FSM SHALL go to IDLE, any burst SHALL abort without fill_done, and data entries SHALL keep their values.
REQ-027 Without LINE_DEMUX_INVALIDATE_EN, the port inv_all SHALL be absent, and line_valid bits SHALL clear only by reset.

Verification
REQ-028 Reset, then single write wr_sel=5, wr_data=37'h1_2345_6789 -> next cycle data5x=37'h1_2345_6789, line_valid=8'h20, fill_done=1 for one cycle.
REQ-029 Burst wr_sel=6, BURST_LEN=8, data k+1 on beat k -> entries 6,7,0..5 hold 1..8, line_valid=8'hFF, fill_done pulses once after the 8th beat.
REQ-030 Burst with wr_valid gaps of 3 cycles between beats -> same final contents as REQ-029, wr_ready stays 1, no early fill_done.
REQ-031 Assert rst_n=0 after beat 3 of a burst -> all outputs 0 and no fill_done; after release, a single write works per REQ-028.
REQ-032 With LINE_DEMUX_INVALIDATE_EN, pulse inv_all during beat 4 of a burst -> beat dropped, line_valid=0, FSM=IDLE, data entries unchanged, no fill_done.
REQ-033 Back-to-back single writes to entries 0 and 0 in consecutive cycles -> data0x shows the second value one cycle after the second beat, fill_done high for two cycles.
